// File: rtl/sl_rx_pkg.sv
// Shared types for the SL receiver.
// Holds the line event codes produced by the decoder, the receiver state
// encoding, the per-frame status word and the bit positions inside it.
package sl_rx_pkg;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_ZERO,
      EV_ONE,
      EV_BOTH,
      EV_LEVEL
   } sl_event_e;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      DRAIN
   } sl_rx_state_e;

   typedef struct packed {
      logic tout;
      logic lvl;
      logic len;
      logic par;
   } sl_rx_status_t;

   localparam int STATUS_PAR_BIT  = 0;
   localparam int STATUS_LEN_BIT  = 1;
   localparam int STATUS_LVL_BIT  = 2;
   localparam int STATUS_TOUT_BIT = 3;

endpackage

// File: rtl/sl_line_decoder.sv
// SL line decoder: synchronises both asynchronous SL lines and turns each
// excursion away from the idle (1,1) pair into one event strobe.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   serial_line_zeroes_a     asynchronous zeroes line (idle high)
//   serial_line_ones_a       asynchronous ones line (idle high)
//   lineEvent                one-cycle event code, EV_NONE otherwise
module sl_line_decoder
   import sl_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SKEW_CYC    = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      serial_line_zeroes_a,
   input  logic      serial_line_ones_a,
   output sl_event_e lineEvent
);

   localparam int SW = $clog2(SKEW_CYC + 2);
   localparam logic [SW-1:0] SKEW_SAT   = SW'(SKEW_CYC + 1);
   localparam logic [SW-1:0] SKEW_LIMIT = SW'(SKEW_CYC);

   logic [SYNC_STAGES-1:0] zeroesSync;
   logic [SYNC_STAGES-1:0] onesSync;
   logic                   zeroesLow;
   logic                   onesLow;
   logic                   inPulse;
   logic                   firstIsZero;
   logic                   escalated;
   logic [SW-1:0]          skewCnt;

   // Synchroniser chains; they reset to the idle-high level so that leaving
   // reset never looks like a falling line.
   always_ff @(posedge clk) begin
      if (rst) begin
         zeroesSync <= '1;
         onesSync   <= '1;
      end else begin
         zeroesSync <= {zeroesSync[SYNC_STAGES-2:0], serial_line_zeroes_a};
         onesSync   <= {onesSync[SYNC_STAGES-2:0], serial_line_ones_a};
      end
   end

   assign zeroesLow = !zeroesSync[SYNC_STAGES-1];
   assign onesLow   = !onesSync[SYNC_STAGES-1];

   // Pulse tracker: remembers which line fell first and how long ago, so the
   // second fall can be judged as a BOTH (inside the skew window) or a LEVEL
   // error. Once a two-line event has been reported the pulse is marked
   // escalated and stays silent until the pair is back at (1,1).
   always_ff @(posedge clk) begin
      if (rst) begin
         inPulse     <= 1'b0;
         firstIsZero <= 1'b0;
         escalated   <= 1'b0;
         skewCnt     <= '0;
      end else if (!zeroesLow && !onesLow) begin
         inPulse   <= 1'b0;
         escalated <= 1'b0;
         skewCnt   <= '0;
      end else begin
         if (!inPulse) begin
            inPulse     <= 1'b1;
            firstIsZero <= zeroesLow;
            skewCnt     <= SW'(1);
         end else if (skewCnt != SKEW_SAT) begin
            skewCnt <= skewCnt + SW'(1);
         end
         if (zeroesLow && onesLow) begin
            escalated <= 1'b1;
         end
      end
   end

   // Event classification. A single-line pulse only commits when the pair
   // returns to idle, because until then it may still turn into a BOTH.
   always_comb begin
      lineEvent = EV_NONE;
      if (!zeroesLow && !onesLow) begin
         if (inPulse && !escalated) begin
            lineEvent = firstIsZero ? EV_ZERO : EV_ONE;
         end
      end else if (zeroesLow && onesLow && !escalated) begin
         if (!inPulse || skewCnt <= SKEW_LIMIT) begin
            lineEvent = EV_BOTH;
         end else begin
            lineEvent = EV_LEVEL;
         end
      end
   end

endmodule

// File: rtl/sl_receiver_fifo.sv
// SL receiver with per-frame status and a ready/valid output FIFO.
// Decodes variable-length SL words (length set through the config port),
// checks the parity slot and the stop, flags level and length errors and
// queues one {status, length, data} entry per frame.
// Optional feature: define SL_RX_TIMEOUT_EN to build the mid-frame idle
// timer and the tout status bit; without it a stalled frame waits forever.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   serial_line_zeroes_a/ones_a   asynchronous SL lines
//   cfg_wr, cfg_len, cfg_pce      config write strobe, word length, parity control
//   cfg_rej                       one-cycle pulse when a config write is refused
//   rx_valid, rx_ready            FIFO head handshake
//   rx_data, rx_len, rx_status    FIFO head contents ({tout, lvl, len, par})
//   fifo_count, ovf, busy         occupancy, sticky overflow, frame in progress
module sl_receiver_fifo
   import sl_rx_pkg::*;
#(
   parameter  int MAX_LEN     = 32,
   parameter  int FIFO_DEPTH  = 4,
   parameter  int SYNC_STAGES = 2,
   parameter  int SKEW_CYC    = 2,
   parameter  int TIMEOUT_CYC = 4096,
   localparam int LW          = $clog2(MAX_LEN + 1),
   localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               serial_line_zeroes_a,
   input  logic               serial_line_ones_a,
   input  logic               cfg_wr,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_pce,
   output logic               cfg_rej,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic [MAX_LEN-1:0] rx_data,
   output logic [LW-1:0]      rx_len,
   output logic [3:0]         rx_status,
   output logic [CW-1:0]      fifo_count,
   output logic               ovf,
   output logic               busy
);

   localparam int PW = $clog2(FIFO_DEPTH);

   sl_event_e          lineEvent;
   sl_rx_state_e       state, stateNext;
   logic [LW-1:0]      cfgLen;
   logic               cfgPce;
   logic               cfgRej;
   logic               cfgOk;
   logic [LW-1:0]      count, countNext;
   logic [MAX_LEN-1:0] shiftData, dataNext, pushData;
   logic               zerosOdd, zerosOddNext;
   logic               onesOdd, onesOddNext;
   sl_rx_status_t      frameStatus, statusNext, pushStatus;
   logic               push;
   logic               isBit;
   logic               bitVal;
   logic               timeoutHit;

   logic [MAX_LEN-1:0] dataMem [FIFO_DEPTH];
   logic [LW-1:0]      lenMem [FIFO_DEPTH];
   sl_rx_status_t      statusMem [FIFO_DEPTH];
   logic [PW-1:0]      wrPtr, rdPtr;
   logic [CW-1:0]      fifoCount;
   logic               ovfReg;
   logic               pop, pushReq, pushAccept;

   sl_line_decoder #(
      .SYNC_STAGES(SYNC_STAGES),
      .SKEW_CYC   (SKEW_CYC)
   ) u_decoder (
      .clk                 (clk),
      .rst                 (rst),
      .serial_line_zeroes_a(serial_line_zeroes_a),
      .serial_line_ones_a  (serial_line_ones_a),
      .lineEvent           (lineEvent)
   );

   assign cfgOk  = cfg_wr && !cfg_len[0] && (cfg_len >= LW'(8)) && (cfg_len <= LW'(MAX_LEN));
   assign isBit  = (lineEvent == EV_ZERO) || (lineEvent == EV_ONE);
   assign bitVal = (lineEvent == EV_ONE);

`ifdef SL_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] idleCnt;
   logic          frameLive;

   assign frameLive  = state inside {DATA, PARITY, STOP};
   assign timeoutHit = frameLive && (lineEvent == EV_NONE) && (idleCnt == TW'(TIMEOUT_CYC - 1));

   // Idle timer: counts quiet cycles while a frame is open and restarts on
   // every event, outside a live frame and on a config write.
   always_ff @(posedge clk) begin
      if (rst || cfgOk || !frameLive || lineEvent != EV_NONE || timeoutHit) begin
         idleCnt <= '0;
      end else begin
         idleCnt <= idleCnt + TW'(1);
      end
   end
`else
   // Without the timer a frame never times out; a non-negative timeout
   // setting makes this permanently false.
   assign timeoutHit = (TIMEOUT_CYC < 0);
`endif

   // Frame FSM next-state logic. Bits are written into position count, and
   // the zero/one counts are kept as running parities for the parity slot.
   // Status bits gathered before DRAIN ride in frameStatus until the stop.
   always_comb begin
      stateNext    = state;
      countNext    = count;
      dataNext     = shiftData;
      zerosOddNext = zerosOdd;
      onesOddNext  = onesOdd;
      statusNext   = frameStatus;
      pushStatus   = frameStatus;
      push         = 1'b0;
      case (state)
         IDLE: begin
            if (isBit) begin
               stateNext    = DATA;
               dataNext     = {{(MAX_LEN-1){1'b0}}, bitVal};
               countNext    = LW'(1);
               zerosOddNext = !bitVal;
               onesOddNext  = bitVal;
               statusNext   = '0;
            end
         end
         DATA: begin
            if (isBit) begin
               dataNext     = shiftData | ({{(MAX_LEN-1){1'b0}}, bitVal} << count);
               countNext    = count + LW'(1);
               zerosOddNext = zerosOdd ^ !bitVal;
               onesOddNext  = onesOdd ^ bitVal;
               if (count + LW'(1) == cfgLen) begin
                  stateNext = PARITY;
               end
            end else if (lineEvent == EV_BOTH) begin
               pushStatus.len = 1'b1;
               push           = 1'b1;
               stateNext      = IDLE;
            end else if (lineEvent == EV_LEVEL) begin
               statusNext.lvl = 1'b1;
               stateNext      = DRAIN;
            end
         end
         PARITY: begin
            // ZERO carries the pair (0,1), ONE carries (1,0); the expected
            // pair is (1 ^ zeros odd, ones odd).
            if (isBit) begin
               statusNext.par = (bitVal != !zerosOdd) || (!bitVal != onesOdd);
               stateNext      = STOP;
            end else if (lineEvent == EV_BOTH) begin
               pushStatus.par = 1'b1;
               push           = 1'b1;
               stateNext      = IDLE;
            end else if (lineEvent == EV_LEVEL) begin
               statusNext.lvl = 1'b1;
               stateNext      = DRAIN;
            end
         end
         STOP: begin
            if (lineEvent == EV_BOTH) begin
               push      = 1'b1;
               stateNext = IDLE;
            end else if (isBit) begin
               statusNext.len = 1'b1;
               stateNext      = DRAIN;
            end else if (lineEvent == EV_LEVEL) begin
               statusNext.lvl = 1'b1;
               stateNext      = DRAIN;
            end
         end
         DRAIN: begin
            if (lineEvent == EV_BOTH) begin
               push      = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
      if (timeoutHit) begin
         pushStatus      = frameStatus;
         pushStatus.tout = 1'b1;
         push            = 1'b1;
         stateNext       = IDLE;
      end
   end

   assign pushData = (cfgPce && pushStatus.par) ? '0 : shiftData;

   // State and config registers. A valid config write wins over any event in
   // the same cycle and drops the open frame; a bad one only raises cfgRej.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cfgLen      <= LW'(MAX_LEN);
         cfgPce      <= 1'b0;
         cfgRej      <= 1'b0;
         count       <= '0;
         shiftData   <= '0;
         zerosOdd    <= 1'b0;
         onesOdd     <= 1'b0;
         frameStatus <= '0;
      end else begin
         cfgRej <= cfg_wr && !cfgOk;
         if (cfgOk) begin
            cfgLen <= cfg_len;
            cfgPce <= cfg_pce;
            state  <= IDLE;
         end else begin
            state       <= stateNext;
            count       <= countNext;
            shiftData   <= dataNext;
            zerosOdd    <= zerosOddNext;
            onesOdd     <= onesOddNext;
            frameStatus <= statusNext;
         end
      end
   end

   assign pop        = rx_valid && rx_ready;
   assign pushReq    = push && !cfgOk;
   assign pushAccept = pushReq && ((fifoCount != CW'(FIFO_DEPTH)) || pop);

   // FIFO pointers, occupancy and the sticky overflow flag. A push into a
   // full FIFO is only accepted when the head leaves in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         ovfReg    <= 1'b0;
      end else begin
         if (pushAccept) wrPtr <= wrPtr + PW'(1);
         if (pop) rdPtr <= rdPtr + PW'(1);
         case ({pushAccept, pop})
            2'b10:   fifoCount <= fifoCount + CW'(1);
            2'b01:   fifoCount <= fifoCount - CW'(1);
            default: fifoCount <= fifoCount;
         endcase
         if (cfgOk) begin
            ovfReg <= 1'b0;
         end else if (pushReq && !pushAccept) begin
            ovfReg <= 1'b1;
         end
      end
   end

   // FIFO storage. Not reset; the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (pushAccept) begin
         dataMem[wrPtr]   <= pushData;
         lenMem[wrPtr]    <= count;
         statusMem[wrPtr] <= pushStatus;
      end
   end

   assign rx_valid   = (fifoCount != '0);
   assign rx_data    = rx_valid ? dataMem[rdPtr] : '0;
   assign rx_len     = rx_valid ? lenMem[rdPtr] : '0;
   assign rx_status  = rx_valid ? statusMem[rdPtr] : '0;
   assign fifo_count = fifoCount;
   assign ovf        = ovfReg;
   assign cfg_rej    = cfgRej;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sl_receiver_fifo.sv
// Testbench for sl_receiver_fifo with default parameters.
// Stimulus queues the hand-computed entry for every frame it sends; a
// separate monitor pops that queue on each FIFO handshake and compares.
module tb_sl_receiver_fifo;

   localparam int MAX_LEN = 32;
   localparam int LW      = 6;
   localparam int CW      = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               zeroesLine;
   logic               onesLine;
   logic               cfgWr;
   logic [LW-1:0]      cfgLen;
   logic               cfgPce;
   logic               cfg_rej;
   logic               rx_valid;
   logic               rxReady;
   logic [MAX_LEN-1:0] rx_data;
   logic [LW-1:0]      rx_len;
   logic [3:0]         rx_status;
   logic [CW-1:0]      fifo_count;
   logic               ovf;
   logic               busy;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  len;
      logic [3:0]  status;
   } expEntry_t;

   expEntry_t expQ[$];
   int        nChecks = 0;
   int        nFails  = 0;

   sl_receiver_fifo dut (
      .clk                 (clk),
      .rst                 (rst),
      .serial_line_zeroes_a(zeroesLine),
      .serial_line_ones_a  (onesLine),
      .cfg_wr              (cfgWr),
      .cfg_len             (cfgLen),
      .cfg_pce             (cfgPce),
      .cfg_rej             (cfg_rej),
      .rx_valid            (rx_valid),
      .rx_ready            (rxReady),
      .rx_data             (rx_data),
      .rx_len              (rx_len),
      .rx_status           (rx_status),
      .fifo_count          (fifo_count),
      .ovf                 (ovf),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic expectEntry(input logic [31:0] data, input logic [5:0] len, input logic [3:0] status);
      expEntry_t e;
      e.data   = data;
      e.len    = len;
      e.status = status;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic zeroes, input logic ones, input int cycles);
      zeroesLine = zeroes;
      onesLine   = ones;
      repeat (cycles) @(posedge clk);
   endtask

   task automatic sendBit(input logic b);
      applyStimulus(b, !b, 3);
      applyStimulus(1'b1, 1'b1, 3);
   endtask

   task automatic sendStop();
      applyStimulus(1'b0, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 3);
   endtask

   // paritySel: 0 = ZERO pulse, 1 = ONE pulse, 2 = both lines, 3 = no slot
   task automatic sendFrame(input logic [31:0] word, input int nBits, input int paritySel);
      for (int i = 0; i < nBits; i++) sendBit(word[i]);
      case (paritySel)
         0:       sendBit(1'b0);
         1:       sendBit(1'b1);
         2:       sendStop();
         default: ;
      endcase
      sendStop();
   endtask

   task automatic writeCfg(input logic [LW-1:0] len, input logic pce, input logic expectRej);
      @(posedge clk); #1;
      cfgWr  = 1'b1;
      cfgLen = len;
      cfgPce = pce;
      @(posedge clk); #1;
      cfgWr = 1'b0;
      @(negedge clk);
      checkOutput("cfgRej", {63'd0, cfg_rej}, {63'd0, expectRej});
   endtask

   task automatic setReady(input logic r);
      @(posedge clk); #1;
      rxReady = r;
   endtask

   task automatic waitDrain(input int budget);
      int waited = 0;
      while (expQ.size() != 0 && waited < budget) begin
         @(posedge clk);
         waited++;
      end
      @(posedge clk);
      @(negedge clk);
      nChecks++;
      if (expQ.size() != 0) begin
         nFails++;
         $display("[TB] FAIL drain: %0d entries never appeared, expected 0 pending", expQ.size());
      end
   endtask

   // Monitor: every accepted FIFO head is compared with the oldest
   // outstanding expectation.
   initial begin
      expEntry_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && rx_valid === 1'b1 && rxReady === 1'b1) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpectedEntry: got data 0x%0h len %0d status %b, expected no entry",
                        rx_data, rx_len, rx_status);
            end else begin
               e = expQ.pop_front();
               checkOutput("rxData", {32'd0, rx_data}, {32'd0, e.data});
               checkOutput("rxLen", {58'd0, rx_len}, {58'd0, e.len});
               checkOutput("rxStatus", {60'd0, rx_status}, {60'd0, e.status});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: time limit reached with %0d entries pending", expQ.size());
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [LW-1:0] badLens [4];
      badLens = '{6'd7, 6'd9, 6'd34, 6'd6};

      rst        = 1'b1;
      zeroesLine = 1'b1;
      onesLine   = 1'b1;
      cfgWr      = 1'b0;
      cfgLen     = '0;
      cfgPce     = 1'b0;
      rxReady    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset checks");
      checkOutput("resetValid", {63'd0, rx_valid}, 64'd0);
      checkOutput("resetCount", {61'd0, fifo_count}, 64'd0);
      checkOutput("resetOvf", {63'd0, ovf}, 64'd0);
      checkOutput("resetBusy", {63'd0, busy}, 64'd0);
      checkOutput("resetRej", {63'd0, cfg_rej}, 64'd0);
      checkOutput("resetData", {32'd0, rx_data}, 64'd0);

      $display("[TB] rejected config writes");
      for (int i = 0; i < 4; i++) writeCfg(badLens[i], 1'b1, 1'b1);

      $display("[TB] full-length frame with reset config");
      expectEntry(32'hDEADBEEF, 6'd32, 4'b0000);
      sendFrame(32'hDEADBEEF, 32, 1);
      waitDrain(200);

      $display("[TB] len 8, parity on");
      writeCfg(6'd8, 1'b1, 1'b0);
      expectEntry(32'hA5, 6'd8, 4'b0000);
      sendFrame(32'hA5, 8, 1);
      expectEntry(32'h07, 6'd8, 4'b0000);
      sendFrame(32'h07, 8, 0);
      expectEntry(32'h0, 6'd8, 4'b0001);
      sendFrame(32'h07, 8, 1);
      expectEntry(32'hB, 6'd4, 4'b0010);
      sendFrame(32'hB, 4, 3);
      waitDrain(200);

      $display("[TB] len 16, both-lines parity slot, parity on");
      writeCfg(6'd16, 1'b1, 1'b0);
      setReady(1'b0);
      expectEntry(32'h0, 6'd16, 4'b0001);
      sendFrame(32'h1234, 16, 2);
      expectEntry(32'h00FF, 6'd16, 4'b0000);
      sendFrame(32'h00FF, 16, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("fifoCountTwo", {61'd0, fifo_count}, 64'd2);
      setReady(1'b1);
      waitDrain(200);

      $display("[TB] len 16, both-lines parity slot, parity off");
      writeCfg(6'd16, 1'b0, 1'b0);
      expectEntry(32'h1234, 6'd16, 4'b0001);
      sendFrame(32'h1234, 16, 2);
      expectEntry(32'h00FF, 6'd16, 4'b0000);
      sendFrame(32'h00FF, 16, 1);
      waitDrain(200);

      $display("[TB] over-long frame then recovery");
      writeCfg(6'd8, 1'b1, 1'b0);
      expectEntry(32'h3C, 6'd8, 4'b0010);
      sendFrame(32'h33C, 10, 0);
      expectEntry(32'h81, 6'd8, 4'b0000);
      sendFrame(32'h81, 8, 1);
      waitDrain(200);

      $display("[TB] level error on bit 3 then recovery");
      expectEntry(32'h05, 6'd3, 4'b0100);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      applyStimulus(1'b0, 1'b1, 6);
      applyStimulus(1'b0, 1'b0, 3);
      @(negedge clk);
      checkOutput("busyDrain", {63'd0, busy}, 64'd1);
      applyStimulus(1'b1, 1'b1, 3);
      sendStop();
      expectEntry(32'h5A, 6'd8, 4'b0000);
      sendFrame(32'h5A, 8, 1);
      waitDrain(200);
      checkOutput("busyIdle", {63'd0, busy}, 64'd0);

      $display("[TB] overflow with consumer stalled");
      setReady(1'b0);
      expectEntry(32'h11, 6'd8, 4'b0000);
      sendFrame(32'h11, 8, 1);
      expectEntry(32'h22, 6'd8, 4'b0000);
      sendFrame(32'h22, 8, 1);
      expectEntry(32'h33, 6'd8, 4'b0000);
      sendFrame(32'h33, 8, 1);
      expectEntry(32'h44, 6'd8, 4'b0000);
      sendFrame(32'h44, 8, 1);
      sendFrame(32'h55, 8, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("fifoCountFull", {61'd0, fifo_count}, 64'd4);
      checkOutput("ovfSet", {63'd0, ovf}, 64'd1);
      setReady(1'b1);
      waitDrain(200);
      checkOutput("fifoCountEmpty", {61'd0, fifo_count}, 64'd0);
      writeCfg(6'd8, 1'b1, 1'b0);
      checkOutput("ovfCleared", {63'd0, ovf}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
